// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension execute unit: operand width,
// funct3/funct7 encodings and the multiply/divide sequencer states.
package rv32_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for the iterative multiplier/divider: turns signed
// operands into magnitudes and reports which results need negating afterwards.
module muldiv_operand_prep import rv32_pkg::*; (
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] mag_a_o,
   output logic [XLEN-1:0] mag_b_o,
   output logic            neg_res_o,
   output logic            neg_rem_o
);

   logic signed_a;
   logic signed_b;
   logic neg_a;
   logic neg_b;

   // Signedness per operation, then magnitude and result-sign derivation.
   // MUL keeps both operands unsigned: its low word does not depend on sign.
   always_comb begin
      signed_a  = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                  (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
      signed_b  = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                  (funct3_i == F3_REM);
      neg_a     = signed_a && rs1_i[XLEN-1];
      neg_b     = signed_b && rs2_i[XLEN-1];
      mag_a_o   = neg_a ? (-rs1_i) : rs1_i;
      mag_b_o   = neg_b ? (-rs2_i) : rs2_i;
      // Product/quotient sign is the XOR of operand signs; the remainder
      // takes the sign of the dividend.
      neg_res_o = neg_a ^ neg_b;
      neg_rem_o = neg_a;
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit. Iterates one bit per cycle (shift-add multiply,
// restoring divide), applies sign correction in a final FIX cycle and pulses
// done with the result. busy stalls the front of the pipeline meanwhile.
//
// Handshake: start is only sampled in IDLE with flush low; busy is high
// combinationally from that cycle through FIX; done is a single-cycle pulse
// in DONE during which result/resultRegisterIndex are valid (and they hold
// afterwards). flush wins over everything and suppresses done.
module ex_muldiv_unit import rv32_pkg::*; (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] exLHSRegisterValue,
   input  logic [31:0] exRHSRegisterValue,
   input  logic [2:0]  exFunct3,
   input  logic [4:0]  exWriteRegisterIndex,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  resultRegisterIndex
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(XLEN - 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [4:0]         rd_q, rd_d;
   logic [XLEN-1:0]    mag_b_q, mag_b_d;
   // Multiply: {partial high, multiplier shifting out}.
   // Divide:   {partial remainder, dividend shifting into quotient}.
   logic [2*XLEN-1:0]  acc_q, acc_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic [4:0]         res_rd_q, res_rd_d;

   logic [XLEN-1:0]    prep_mag_a;
   logic [XLEN-1:0]    prep_mag_b;
   logic               prep_neg_res;
   logic               prep_neg_rem;

   logic               div_zero;
   logic               div_ovf;
   logic               fast_path;
   logic [XLEN-1:0]    fast_value;

   logic [XLEN:0]      mul_sum;
   logic [2*XLEN-1:0]  mul_next;
   logic [XLEN:0]      div_trial;
   logic [XLEN:0]      div_diff;
   logic               div_ge;
   logic [2*XLEN-1:0]  div_next;

   logic [2*XLEN-1:0]  prod_fix;
   logic [XLEN-1:0]    quot_fix;
   logic [XLEN-1:0]    rem_fix;
   logic [XLEN-1:0]    fix_value;

   muldiv_operand_prep u_prep (
      .rs1_i     (exLHSRegisterValue),
      .rs2_i     (exRHSRegisterValue),
      .funct3_i  (exFunct3),
      .mag_a_o   (prep_mag_a),
      .mag_b_o   (prep_mag_b),
      .neg_res_o (prep_neg_res),
      .neg_rem_o (prep_neg_rem)
   );

   // Divide-by-zero and signed overflow finish immediately with fixed results.
   always_comb begin
      div_zero   = exFunct3[2] && (exRHSRegisterValue == '0);
      div_ovf    = exFunct3[2] && !exFunct3[0] &&
                   (exLHSRegisterValue == 32'h8000_0000) &&
                   (exRHSRegisterValue == 32'hFFFF_FFFF);
      fast_path  = div_zero || div_ovf;
      if (div_zero) fast_value = exFunct3[1] ? exLHSRegisterValue : '1;
      else          fast_value = exFunct3[1] ? '0 : 32'h8000_0000;
   end

   // One iteration step of both datapaths; RUN picks one by funct3.
   // The remainder invariant (rem < divisor) keeps the difference in 32 bits
   // when the trial succeeds, so its top bit doubles as the borrow.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  {1'b0, (acc_q[0] ? mag_b_q : {XLEN{1'b0}})};
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_trial - {1'b0, mag_b_q};
      div_ge    = !div_diff[XLEN];
      div_next  = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                         : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   // Sign correction and word selection for the FIX cycle.
   always_comb begin
      prod_fix = neg_res_q ? (-acc_q) : acc_q;
      quot_fix = neg_res_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      rem_fix  = neg_rem_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      case (funct3_q)
         F3_MUL:                       fix_value = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              fix_value = quot_fix;
         default:                      fix_value = rem_fix;
      endcase
   end

   // Sequencer next-state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      funct3_d  = funct3_q;
      rd_d      = rd_q;
      mag_b_d   = mag_b_q;
      acc_d     = acc_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      res_rd_d  = res_rd_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  funct3_d  = exFunct3;
                  rd_d      = exWriteRegisterIndex;
                  mag_b_d   = prep_mag_b;
                  acc_d     = {{XLEN{1'b0}}, prep_mag_a};
                  neg_res_d = prep_neg_res;
                  neg_rem_d = prep_neg_rem;
                  count_d   = '0;
                  if (fast_path) begin
                     result_d = fast_value;
                     res_rd_d = exWriteRegisterIndex;
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               acc_d   = funct3_q[2] ? div_next : mul_next;
               count_d = count_q + 1'b1;
               if (count_q == LAST_COUNT) state_d = ST_FIX;
            end
            ST_FIX: begin
               result_d = fix_value;
               res_rd_d = rd_q;
               state_d  = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         funct3_q  <= '0;
         rd_q      <= '0;
         mag_b_q   <= '0;
         acc_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         res_rd_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         funct3_q  <= funct3_d;
         rd_q      <= rd_d;
         mag_b_q   <= mag_b_d;
         acc_q     <= acc_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         res_rd_q  <= res_rd_d;
      end
   end

   // Stall and completion outputs; both are killed by flush in the same cycle.
   always_comb begin
      busy = !flush && (((state_q == ST_IDLE) && start) ||
                        (state_q == ST_RUN) || (state_q == ST_FIX));
      done = !flush && (state_q == ST_DONE);
      result              = result_q;
      resultRegisterIndex = res_rd_q;
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: reference model feeding a result
// queue, latency and busy accounting per operation, flush/reset abort cases.
module tb_ex_muldiv_unit;
   import rv32_pkg::*;

   logic        clk;
   logic        resetN;
   logic        start;
   logic        flush;
   logic [31:0] exLHSRegisterValue;
   logic [31:0] exRHSRegisterValue;
   logic [2:0]  exFunct3;
   logic [4:0]  exWriteRegisterIndex;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  resultRegisterIndex;

   logic [31:0] exp_q[$];
   logic [4:0]  exp_rd_q[$];
   logic [31:0] last_exp;
   int          n_checks;
   int          n_errors;

   ex_muldiv_unit dut (
      .clk                  (clk),
      .resetN               (resetN),
      .start                (start),
      .flush                (flush),
      .exLHSRegisterValue   (exLHSRegisterValue),
      .exRHSRegisterValue   (exRHSRegisterValue),
      .exFunct3             (exFunct3),
      .exWriteRegisterIndex (exWriteRegisterIndex),
      .busy                 (busy),
      .done                 (done),
      .result               (result),
      .resultRegisterIndex  (resultRegisterIndex)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference RV32M semantics built from native 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] pu;
      int          ia, ib;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = {32'h0, b};
      ia  = int'($signed(a));
      ib  = int'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b000: begin p = sa * sb; ref_model = p[31:0]; end
         3'b001: begin p = sa * sb; ref_model = p[63:32]; end
         3'b010: begin p = sa * ub; ref_model = p[63:32]; end
         3'b011: begin pu = {32'h0, a} * {32'h0, b}; ref_model = pu[63:32]; end
         3'b100: ref_model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
         3'b101: ref_model = (b == 0) ? 32'hFFFF_FFFF : (a / b);
         3'b110: ref_model = (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
         default: ref_model = (b == 0) ? a : (a % b);
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f3,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   // Issue one operation at the next cycle, hold start while stalled, and
   // check latency, busy cycles and the scoreboarded result on done.
   // With chain set, start stays high through the done cycle.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input bit chain);
      int          k;
      int          busy_cyc;
      int          lat;
      bit          seen;
      logic [31:0] e_res;
      logic [4:0]  e_rd;
      @(posedge clk); #1;
      start = 1'b1;
      exFunct3 = f3;
      exLHSRegisterValue = a;
      exRHSRegisterValue = b;
      exWriteRegisterIndex = rd;
      exp_q.push_back(ref_model(f3, a, b));
      exp_rd_q.push_back(rd);
      lat = exp_latency(f3, a, b);
      #1;
      k = 0; busy_cyc = 0; seen = 1'b0;
      while (!seen && k < 100) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            k++;
         end
      end
      e_res = exp_q.pop_front();
      e_rd  = exp_rd_q.pop_front();
      last_exp = e_res;
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL done_timeout f3=%0d a=%h b=%h: no done within 100 cycles", f3, a, b);
      end else begin
         if (k !== lat) begin
            n_errors++;
            $display("FAIL latency f3=%0d a=%h b=%h: got %0d required %0d", f3, a, b, k, lat);
         end
         n_checks++;
         if (busy_cyc !== lat) begin
            n_errors++;
            $display("FAIL busy_cycles f3=%0d: got %0d required %0d", f3, busy_cyc, lat);
         end
         n_checks++;
         if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_in_done f3=%0d: got %b required 0", f3, busy);
         end
         n_checks++;
         if (result !== e_res) begin
            n_errors++;
            $display("FAIL result f3=%0d a=%h b=%h: got %h required %h", f3, a, b, result, e_res);
         end
         n_checks++;
         if (resultRegisterIndex !== e_rd) begin
            n_errors++;
            $display("FAIL result_rd f3=%0d: got %0d required %0d", f3, resultRegisterIndex, e_rd);
         end
      end
      if (!chain) start = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b0; start = 1'b0; flush = 1'b0;
      exLHSRegisterValue = '0; exRHSRegisterValue = '0;
      exFunct3 = '0; exWriteRegisterIndex = '0;
      #3;
      n_checks++;
      if ({busy, done, result, resultRegisterIndex} !== 39'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h rd=%0d required all 0",
                  busy, done, result, resultRegisterIndex);
      end
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (dut.state_q !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: got state=%0d busy=%b done=%b required IDLE/0/0",
                  dut.state_q, busy, done);
      end
   endtask

   task automatic test_mul();
      run_op(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  1'b0);
      n_checks++;
      if (result !== 32'hFFFF_FFEB) begin
         n_errors++;
         $display("FAIL mul_7x-3: got %h required ffffffeb", result);
      end
      run_op(F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
      run_op(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
      run_op(F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
      run_op(F3_MULH,   32'h1234_5678, 32'h8765_4321, 5'd13, 1'b0);
   endtask

   task automatic test_div();
      run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd14, 1'b0);
      run_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd15, 1'b0);
      run_op(F3_DIVU, 32'd100,       32'd7, 5'd16, 1'b0);
      run_op(F3_REMU, 32'd100,       32'd7, 5'd17, 1'b0);
      run_op(F3_DIVU, 32'hFFFF_FFFF, 32'h1, 5'd18, 1'b0);
      run_op(F3_REM,  32'd37,  32'hFFFF_FFFB, 5'd19, 1'b0);
   endtask

   task automatic test_fast_path();
      run_op(F3_DIVU, 32'd5,         32'd0,         5'd20, 1'b0);
      run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 1'b0);
      run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 1'b0);
      run_op(F3_REMU, 32'hDEAD_BEEF, 32'd0,         5'd23, 1'b0);
      run_op(F3_DIV,  32'hFFFF_FFF0, 32'd0,         5'd24, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(1, 31)), 1'b0);
      end
   endtask

   task automatic test_flush();
      int dones;
      @(posedge clk); #1;
      start = 1'b1; exFunct3 = F3_MUL;
      exLHSRegisterValue = 32'd1234; exRHSRegisterValue = 32'd5678;
      exWriteRegisterIndex = 5'd3;
      repeat (11) @(posedge clk);
      #1;
      n_checks++;
      if (dut.count_q !== 5'd10) begin
         n_errors++;
         $display("FAIL flush_count: got %0d required 10", dut.count_q);
      end
      flush = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_busy: got busy=%b done=%b required 0/0", busy, done);
      end
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      n_checks++;
      if (dut.state_q !== ST_IDLE) begin
         n_errors++;
         $display("FAIL flush_state: got %0d required IDLE", dut.state_q);
      end
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || result !== last_exp) begin
         n_errors++;
         $display("FAIL flush_no_done: got %0d dones result=%h required 0 dones result=%h",
                  dones, result, last_exp);
      end
      // flush beats start in IDLE
      start = 1'b1; flush = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_priority_busy: got %b required 0", busy);
      end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      n_checks++;
      if (dut.state_q !== ST_IDLE) begin
         n_errors++;
         $display("FAIL flush_priority_state: got %0d required IDLE", dut.state_q);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      @(posedge clk); #1;
      start = 1'b1; exFunct3 = F3_DIVU;
      exLHSRegisterValue = 32'd1000; exRHSRegisterValue = 32'd3;
      exWriteRegisterIndex = 5'd7;
      repeat (6) @(posedge clk);
      #3;
      resetN = 1'b0; start = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, result, resultRegisterIndex} !== 39'h0 || dut.state_q !== ST_IDLE) begin
         n_errors++;
         $display("FAIL reset_mid_run: got busy=%b done=%b result=%h rd=%0d state=%0d required all 0/IDLE",
                  busy, done, result, resultRegisterIndex, dut.state_q);
      end
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || result !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_no_done: got %0d dones result=%h required 0 dones result=0",
                  dones, result);
      end
   endtask

   task automatic test_back_to_back();
      run_op(F3_MUL, 32'd11, 32'd13, 5'd5, 1'b1);
      // Next instruction presents itself while the first is in DONE.
      exLHSRegisterValue = 32'd3; exRHSRegisterValue = 32'd4;
      exWriteRegisterIndex = 5'd6;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_busy_in_done: got %b required 0", busy);
      end
      run_op(F3_MUL, 32'd3, 32'd4, 5'd6, 1'b0);
      n_checks++;
      if (result !== 32'd12) begin
         n_errors++;
         $display("FAIL b2b_result: got %h required 0000000c", result);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      last_exp = '0;
      test_reset();
      test_mul();
      test_div();
      test_fast_path();
      test_random();
      test_flush();
      test_reset_mid_run();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
